// File: rtl/exec_step_pkg.sv
// Shared encodings for the execution step controller: operating modes
// selected by the mode input and the controller FSM states.
package exec_step_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_BURST  = 2'b10,
        MODE_HALT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, level debouncer and a
// one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    valid;
    logic          armed;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronise, debounce, and arm press detection only once the button
    // has been seen released after reset, so a button held through reset
    // cannot produce a press when its debounced level first rises.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            valid   <= '0;
            armed   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            valid   <= {valid[0], 1'b1};
            level_d <= level;
            if (valid[1] && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d & armed;

endmodule

// File: rtl/exec_step_ctrl.sv
// Execution step controller: turns a debounced push-button and a mode
// selection into single, free-running or counted-burst CPU step pulses.
module exec_step_ctrl
    import exec_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD_W        = 16,
    parameter int BURST_W         = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                exec,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                cpu_ready,
    output logic                step,
    output logic                busy,
    output logic [BURST_W-1:0]  burst_left,
    output logic [15:0]         step_count
);

    state_t              state;
    state_t              state_n;
    mode_t               mode_cur;
    mode_t               mode_q;
    logic                mode_chg;
    logic                press;
    logic                pending;
    logic                pending_n;
    logic [PERIOD_W-1:0] tick_cnt;
    logic [PERIOD_W-1:0] tick_n;
    logic [PERIOD_W-1:0] period_eff;
    logic                tick_due;
    logic [BURST_W-1:0]  burst_left_n;
    logic [15:0]         step_count_n;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_in(clk_in),
        .rst   (rst),
        .btn   (exec),
        .press (press)
    );

    assign mode_cur   = mode_t'(mode);
    assign mode_chg   = (mode_cur != mode_q);
    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
    assign tick_due   = (tick_cnt <= PERIOD_W'(1));

    // A mode change cancels the pending request in the same cycle, so the
    // step gate also masks it to keep step_count unchanged across a change.
    assign step = pending & cpu_ready & ~mode_chg & (mode_cur != MODE_HALT);

    // Next-state, pending request, tick counter, burst and step counters.
    always_comb begin
        state_n      = state;
        pending_n    = pending & ~step;
        tick_n       = tick_cnt;
        burst_left_n = burst_left;
        step_count_n = step ? step_count + 16'd1 : step_count;

        if (mode_chg) begin
            state_n      = ST_IDLE;
            pending_n    = 1'b0;
            tick_n       = '0;
            burst_left_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (press) begin
                        unique case (mode_cur)
                            MODE_SINGLE: begin
                                pending_n = 1'b1;
                            end
                            MODE_RUN: begin
                                state_n   = ST_RUN;
                                pending_n = 1'b1;
                                tick_n    = period_eff;
                            end
                            MODE_BURST: begin
                                if (burst_len != '0) begin
                                    state_n      = ST_BURST;
                                    pending_n    = 1'b1;
                                    tick_n       = period_eff;
                                    burst_left_n = burst_len;
                                end
                            end
                            MODE_HALT: begin
                            end
                        endcase
                    end
                end

                ST_RUN: begin
                    if (press) begin
                        state_n   = ST_IDLE;
                        pending_n = 1'b0;
                        tick_n    = '0;
                    end else if (tick_due) begin
                        pending_n = 1'b1;
                        tick_n    = period_eff;
                    end else begin
                        tick_n = tick_cnt - PERIOD_W'(1);
                    end
                end

                ST_BURST: begin
                    if (tick_due) begin
                        pending_n = 1'b1;
                        tick_n    = period_eff;
                    end else begin
                        tick_n = tick_cnt - PERIOD_W'(1);
                    end
                    // The last step ends the burst; any tick raised in the
                    // same cycle must not leak a step into IDLE.
                    if (step) begin
                        burst_left_n = burst_left - BURST_W'(1);
                        if (burst_left <= BURST_W'(1)) begin
                            state_n      = ST_IDLE;
                            pending_n    = 1'b0;
                            tick_n       = '0;
                            burst_left_n = '0;
                        end
                    end
                end

                default: begin
                    state_n   = ST_IDLE;
                    pending_n = 1'b0;
                end
            endcase
        end
    end

    // State register; busy is registered straight from the next state.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_SINGLE;
            pending    <= 1'b0;
            tick_cnt   <= '0;
            burst_left <= '0;
            step_count <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_cur;
            pending    <= pending_n;
            tick_cnt   <= tick_n;
            burst_left <= burst_left_n;
            step_count <= step_count_n;
            busy       <= (state_n != ST_IDLE);
        end
    end

endmodule
